// File: rtl/player_input_ctrl.sv
// Multi-player button front end: per-key sync + debounce, then one HIT/STAND per turn step over valid/ack.
// Optional idle timeout (forced STAND) is compiled in with PLAYER_INPUT_TIMEOUT_EN.
package player_input_pkg;
    typedef enum logic [1:0] {
        NONE  = 2'd0,
        HIT   = 2'd1,
        STAND = 2'd2
    } gameCommand;
endpackage

module player_input_ctrl
    import player_input_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 50000000,
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [2*NUM_PLAYERS-1:0] KEY,
    input  logic                     turn_valid,
    input  logic [PW-1:0]            turn_player,
    input  logic                     cmd_ack,
    output logic                     cmd_valid,
    output gameCommand               cmd,
    output logic [PW-1:0]            cmd_player,
    output logic [2*NUM_PLAYERS-1:0] keys_pressed
`ifdef PLAYER_INPUT_TIMEOUT_EN
    ,
    output logic                     cmd_timeout
`endif
);

    localparam int NK     = 2 * NUM_PLAYERS;
    localparam int DB_LIM = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0;
    localparam int DBW    = ($clog2(DB_LIM + 1) > 0) ? $clog2(DB_LIM + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        HOLD,
        WAIT_RELEASE
    } state_t;

    logic [NK-1:0] db_vec;
    logic [NK-1:0] db_prev_q;
    logic [NK-1:0] press_ev;
    logic [1:0]    cur_ev;
    logic [1:0]    cur_held;

    state_t        state_q;
    logic [PW-1:0] cur_player_q;
    logic          cmd_valid_q;
    gameCommand    cmd_q;
    logic [PW-1:0] cmd_player_q;

    // Per key: raw is active-low, debounced state is stored active-high.
    generate
        for (genvar gi = 0; gi < NK; gi++) begin : g_key
            logic           sync1_q;
            logic           sync2_q;
            logic           db_q;
            logic [DBW-1:0] cnt_q;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                    db_q    <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= KEY[gi];
                    sync2_q <= sync1_q;
                    if (!sync2_q == db_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DBW'(DB_LIM)) begin
                        db_q  <= ~db_q;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end

            assign db_vec[gi] = db_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            db_prev_q <= '0;
        end else begin
            db_prev_q <= db_vec;
        end
    end

    assign press_ev = db_vec & ~db_prev_q;

    always_comb begin
        cur_ev   = 2'b00;
        cur_held = 2'b00;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (cur_player_q == PW'(p)) begin
                cur_ev   = press_ev[2*p +: 2];
                cur_held = db_vec[2*p +: 2];
            end
        end
    end

`ifdef PLAYER_INPUT_TIMEOUT_EN
    localparam int TO_LIM = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int TOW    = ($clog2(TO_LIM + 1) > 0) ? $clog2(TO_LIM + 1) : 1;
    logic [TOW-1:0] to_cnt_q;
    logic           cmd_timeout_q;
    assign cmd_timeout = cmd_timeout_q;
`else
    // The timeout length only matters when the timeout logic is compiled in.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cur_player_q <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_q        <= NONE;
            cmd_player_q <= '0;
`ifdef PLAYER_INPUT_TIMEOUT_EN
            to_cnt_q      <= '0;
            cmd_timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_valid_q <= 1'b0;
                    cmd_q       <= NONE;
                    if (turn_valid) begin
                        cur_player_q <= turn_player;
                        state_q      <= WAIT_PRESS;
`ifdef PLAYER_INPUT_TIMEOUT_EN
                        to_cnt_q <= '0;
`endif
                    end
                end
                WAIT_PRESS: begin
                    if (!turn_valid) begin
                        state_q <= IDLE;
                    end else if (cur_ev[1]) begin
                        cmd_q        <= STAND;
                        cmd_valid_q  <= 1'b1;
                        cmd_player_q <= cur_player_q;
                        state_q      <= HOLD;
                    end else if (cur_ev[0]) begin
                        cmd_q        <= HIT;
                        cmd_valid_q  <= 1'b1;
                        cmd_player_q <= cur_player_q;
                        state_q      <= HOLD;
`ifdef PLAYER_INPUT_TIMEOUT_EN
                    end else if (to_cnt_q == TOW'(TO_LIM)) begin
                        cmd_q         <= STAND;
                        cmd_valid_q   <= 1'b1;
                        cmd_timeout_q <= 1'b1;
                        cmd_player_q  <= cur_player_q;
                        state_q       <= HOLD;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
`endif
                    end
                end
                HOLD: begin
                    if (!turn_valid) begin
                        cmd_valid_q <= 1'b0;
                        cmd_q       <= NONE;
                        state_q     <= IDLE;
`ifdef PLAYER_INPUT_TIMEOUT_EN
                        cmd_timeout_q <= 1'b0;
`endif
                    end else if (cmd_ack) begin
                        cmd_valid_q <= 1'b0;
                        cmd_q       <= NONE;
                        state_q     <= WAIT_RELEASE;
`ifdef PLAYER_INPUT_TIMEOUT_EN
                        cmd_timeout_q <= 1'b0;
`endif
                    end
                end
                WAIT_RELEASE: begin
                    // A fresh command needs both of this player's keys up first.
                    if (!turn_valid) begin
                        state_q <= IDLE;
                    end else if (cur_held == 2'b00) begin
                        state_q <= WAIT_PRESS;
`ifdef PLAYER_INPUT_TIMEOUT_EN
                        to_cnt_q <= '0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_valid    = cmd_valid_q;
    assign cmd          = cmd_q;
    assign cmd_player   = cmd_player_q;
    assign keys_pressed = db_vec;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Bench for player_input_ctrl: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_player_input_ctrl;
    import player_input_pkg::*;

    localparam int NP = 2;
    localparam int DB = 4;
    localparam int TO = 20;
    localparam int NK = 2 * NP;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [NK-1:0]  key_r = '1;
    logic           turn_valid = 1'b0;
    logic [0:0]     turn_player = 1'b0;
    logic           cmd_ack = 1'b0;
    logic           cmd_valid;
    gameCommand     cmd;
    logic [0:0]     cmd_player;
    logic [NK-1:0]  keys_pressed;
`ifdef PLAYER_INPUT_TIMEOUT_EN
    logic           cmd_timeout;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    player_input_ctrl #(
        .NUM_PLAYERS(NP),
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .KEY(key_r),
        .turn_valid(turn_valid),
        .turn_player(turn_player),
        .cmd_ack(cmd_ack),
        .cmd_valid(cmd_valid),
        .cmd(cmd),
        .cmd_player(cmd_player),
        .keys_pressed(keys_pressed)
`ifdef PLAYER_INPUT_TIMEOUT_EN
        ,
        .cmd_timeout(cmd_timeout)
`endif
    );

    // Reference model: a key's pressed state changes once the raw level, seen two
    // samples late, has shown the opposite state for DB samples in a row.
    logic [NK-1:0] raw_hist[$];
    logic [NK-1:0] m_db, m_db_prev;
    bit            m_open, m_valid, m_armed, m_to;
    gameCommand    m_cmd;
    logic [0:0]    m_cur, m_player;
    int            m_wait;

    always @(posedge clk) begin
        logic [1:0]    ev, held;
        logic [NK-1:0] new_db, s;
        bit            run;
        if (!reset_n) begin
            raw_hist.delete();
            for (int i = 0; i < DB + 2; i++) raw_hist.push_back('1);
            m_db = '0; m_db_prev = '0;
            m_open = 0; m_valid = 0; m_armed = 0; m_to = 0;
            m_cmd = NONE; m_cur = '0; m_player = '0; m_wait = 0;
        end else begin
            ev   = 2'((m_db & ~m_db_prev) >> (2 * m_cur));
            held = 2'(m_db >> (2 * m_cur));
            if (!m_open) begin
                m_valid = 0; m_cmd = NONE;
                if (turn_valid) begin
                    m_open = 1; m_cur = turn_player; m_armed = 1; m_wait = 0;
                end
            end else if (!turn_valid) begin
                m_open = 0; m_valid = 0; m_cmd = NONE; m_to = 0;
            end else if (m_valid) begin
                if (cmd_ack) begin
                    m_valid = 0; m_cmd = NONE; m_to = 0; m_armed = 0;
                end
            end else if (!m_armed) begin
                if (held == 2'b00) begin
                    m_armed = 1; m_wait = 0;
                end
            end else if (ev != 2'b00) begin
                m_valid = 1; m_cmd = ev[1] ? STAND : HIT; m_player = m_cur; m_to = 0;
`ifdef PLAYER_INPUT_TIMEOUT_EN
            end else if (m_wait == TO - 1) begin
                m_valid = 1; m_cmd = STAND; m_player = m_cur; m_to = 1;
            end else begin
                m_wait++;
`endif
            end

            raw_hist.push_back(key_r);
            void'(raw_hist.pop_front());
            new_db = m_db;
            for (int k = 0; k < NK; k++) begin
                run = 1;
                for (int j = 2; j <= DB + 1; j++) begin
                    s = raw_hist[raw_hist.size() - 1 - j];
                    if (!s[k] == m_db[k]) run = 0;
                end
                if (run) new_db[k] = ~m_db[k];
            end
            m_db_prev = m_db;
            m_db = new_db;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic open_turn(input logic [0:0] p);
        turn_valid = 1'b0;
        cyc(2);
        turn_player = p;
        turn_valid = 1'b1;
        cyc(1);
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (cmd_valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic ack_one();
        cmd_ack = 1'b1;
        cyc(1);
        cmd_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; key_r = '1; turn_valid = 1'b0; cmd_ack = 1'b0;
        cyc(3);
        checks++;
        if (cmd_valid !== 1'b0 || cmd !== NONE)
            $display("FAIL reset_cmd: got valid=%0b cmd=%0d, want 0 0", cmd_valid, cmd);
        checks++;
        if (cmd_player !== 1'b0 || keys_pressed !== 4'b0000)
            $display("FAIL reset_misc: got player=%0d keys=%b, want 0 0000", cmd_player, keys_pressed);
`ifdef PLAYER_INPUT_TIMEOUT_EN
        checks++;
        if (cmd_timeout !== 1'b0)
            $display("FAIL reset_timeout: got %0b, want 0", cmd_timeout);
`endif
        if (cmd_valid !== 1'b0 || cmd !== NONE || cmd_player !== 1'b0 || keys_pressed !== 4'b0000) errors++;
`ifdef PLAYER_INPUT_TIMEOUT_EN
        if (cmd_timeout !== 1'b0) errors++;
`endif
        reset_n = 1'b1;
        cyc(2);
        $display("reset: valid=%0b cmd=%0d keys=%b", cmd_valid, cmd, keys_pressed);
    endtask

    task automatic test_latency();
        bit stable;
        open_turn(1'b1);
        cyc(1);
        key_r[2] = 1'b0;
        cyc(6);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got valid=%0b after 6 cycles, want 0", cmd_valid);
        end
        cyc(1);
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== HIT || cmd_player !== 1'b1) begin
            errors++;
            $display("FAIL latency_cmd: got valid=%0b cmd=%0d player=%0d, want 1 1 1", cmd_valid, cmd, cmd_player);
        end
        checks++;
        if (keys_pressed !== 4'b0100) begin
            errors++;
            $display("FAIL latency_keys: got %b, want 0100", keys_pressed);
        end
        stable = 1;
        repeat (4) begin
            cyc(1);
            if (cmd_valid !== 1'b1 || cmd !== HIT || cmd_player !== 1'b1) stable = 0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL hold_stable: got valid=%0b cmd=%0d, want held 1 1", cmd_valid, cmd);
        end
        ack_one();
        checks++;
        if (cmd_valid !== 1'b0 || cmd !== NONE) begin
            errors++;
            $display("FAIL ack_clear: got valid=%0b cmd=%0d, want 0 0", cmd_valid, cmd);
        end
        key_r[2] = 1'b1;
        cyc(DB + 4);
        $display("latency: HIT from player 1 after 7 cycles, acked");
    endtask

    task automatic test_glitch();
        bit quiet, ok;
        open_turn(1'b1);
        key_r[3] = 1'b0;
        cyc(3);
        key_r[3] = 1'b1;
        quiet = 1;
        repeat (10) begin
            cyc(1);
            if (keys_pressed !== 4'b0000 || cmd_valid !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL glitch_ignored: got keys=%b valid=%0b, want 0000 0", keys_pressed, cmd_valid);
        end
        open_turn(1'b1);
        key_r[3] = 1'b0;
        wait_valid(20, ok);
        checks++;
        if (!ok || cmd !== STAND || cmd_player !== 1'b1) begin
            errors++;
            $display("FAIL long_stand: got valid=%0b cmd=%0d player=%0d, want 1 2 1", cmd_valid, cmd, cmd_player);
        end
        cyc(3);
        ack_one();
        key_r[3] = 1'b1;
        cyc(DB + 4);
        $display("glitch: short pulse ignored, long press gave cmd=STAND");
    endtask

    task automatic test_both_keys();
        bit quiet, ok;
        open_turn(1'b1);
        key_r[3:2] = 2'b00;
        wait_valid(20, ok);
        checks++;
        if (!ok || cmd !== STAND) begin
            errors++;
            $display("FAIL both_stand: got valid=%0b cmd=%0d, want 1 2", cmd_valid, cmd);
        end
        ack_one();
        quiet = 1;
        repeat (12) begin
            cyc(1);
            if (cmd_valid !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL held_no_repeat: got valid=%0b while held, want 0", cmd_valid);
        end
        key_r[3:2] = 2'b11;
        cyc(DB + 4);
        key_r[2] = 1'b0;
        wait_valid(20, ok);
        checks++;
        if (!ok || cmd !== HIT) begin
            errors++;
            $display("FAIL repress_hit: got valid=%0b cmd=%0d, want 1 1", cmd_valid, cmd);
        end
        ack_one();
        key_r[2] = 1'b1;
        cyc(DB + 4);
        $display("both_keys: STAND first, HIT after release and re-press");
    endtask

    task automatic test_other_player();
        bit quiet, ok;
        open_turn(1'b1);
        key_r[0] = 1'b0;
        quiet = 1;
        repeat (12) begin
            cyc(1);
            if (cmd_valid !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL other_player: got valid=%0b, want 0", cmd_valid);
        end
        key_r[0] = 1'b1;
        turn_valid = 1'b0;
        cyc(DB + 4);

        key_r[2] = 1'b0;
        cyc(DB + 4);
        open_turn(1'b1);
        quiet = 1;
        repeat (8) begin
            cyc(1);
            if (cmd_valid !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL held_at_start: got valid=%0b, want 0", cmd_valid);
        end
        key_r[2] = 1'b1;
        cyc(DB + 4);
`ifdef PLAYER_INPUT_TIMEOUT_EN
        open_turn(1'b1);
`endif
        key_r[2] = 1'b0;
        wait_valid(20, ok);
        checks++;
        if (!ok || cmd !== HIT || cmd_player !== 1'b1) begin
            errors++;
            $display("FAIL held_then_repress: got valid=%0b cmd=%0d player=%0d, want 1 1 1", cmd_valid, cmd, cmd_player);
        end
        ack_one();
        key_r[2] = 1'b1;
        turn_valid = 1'b0;
        cyc(DB + 4);
        $display("other_player: foreign and pre-held keys ignored");
    endtask

    task automatic test_turn_drop();
        bit ok;
        open_turn(1'b1);
        key_r[2] = 1'b0;
        wait_valid(20, ok);
        turn_valid = 1'b0;
        cyc(1);
        checks++;
        if (!ok || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_in_hold: got ok=%0b valid=%0b, want 1 0", ok, cmd_valid);
        end
        key_r[2] = 1'b1;
        cyc(DB + 4);
        turn_player = 1'b0;
        turn_valid = 1'b1;
        cyc(1);
        key_r[0] = 1'b0;
        wait_valid(20, ok);
        checks++;
        if (!ok || cmd !== HIT || cmd_player !== 1'b0) begin
            errors++;
            $display("FAIL relatch_player: got valid=%0b cmd=%0d player=%0d, want 1 1 0", cmd_valid, cmd, cmd_player);
        end
        reset_n = 1'b0;
        cyc(1);
        checks++;
        if (cmd_valid !== 1'b0 || cmd !== NONE || cmd_player !== 1'b0 || keys_pressed !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_hold: got valid=%0b cmd=%0d player=%0d keys=%b, want 0 0 0 0000",
                     cmd_valid, cmd, cmd_player, keys_pressed);
        end
        reset_n = 1'b1;
        key_r[0] = 1'b1;
        turn_valid = 1'b0;
        cyc(DB + 4);
        $display("turn_drop: command discarded, reset mid-hold cleared outputs");
    endtask

    task automatic test_random(input int n);
        int hold[NK];
        int bad;
        for (int k = 0; k < NK; k++) hold[k] = 0;
        bad = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checks++;
`ifdef PLAYER_INPUT_TIMEOUT_EN
            if ({cmd_valid, cmd, cmd_player, keys_pressed, cmd_timeout} !==
                {m_valid, m_cmd, m_player, m_db, m_to}) begin
                errors++; bad++;
                $display("FAIL random_cycle %0d: got v=%0b c=%0d p=%0d k=%b t=%0b, want %0b %0d %0d %b %0b",
                         c, cmd_valid, cmd, cmd_player, keys_pressed, cmd_timeout, m_valid, m_cmd, m_player, m_db, m_to);
            end
`else
            if ({cmd_valid, cmd, cmd_player, keys_pressed} !== {m_valid, m_cmd, m_player, m_db}) begin
                errors++; bad++;
                $display("FAIL random_cycle %0d: got v=%0b c=%0d p=%0d k=%b, want %0b %0d %0d %b",
                         c, cmd_valid, cmd, cmd_player, keys_pressed, m_valid, m_cmd, m_player, m_db);
            end
`endif
            for (int k = 0; k < NK; k++) begin
                if (hold[k] == 0) begin
                    key_r[k] = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
                    hold[k] = $urandom_range(1, 14);
                end else begin
                    hold[k]--;
                end
            end
            cmd_ack = ($urandom_range(0, 3) == 0);
            turn_player = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 3) turn_valid = ~turn_valid;
        end
        key_r = '1; cmd_ack = 1'b0; turn_valid = 1'b0;
        cyc(DB + 4);
        $display("random: %0d cycles compared, %0d mismatching", n, bad);
    endtask

`ifdef PLAYER_INPUT_TIMEOUT_EN
    task automatic test_timeout();
        open_turn(1'b0);
        cyc(19);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got valid=%0b, want 0", cmd_valid);
        end
        cyc(1);
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== STAND || cmd_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_stand: got valid=%0b cmd=%0d to=%0b, want 1 2 1", cmd_valid, cmd, cmd_timeout);
        end
        ack_one();
        checks++;
        if (cmd_valid !== 1'b0 || cmd_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got valid=%0b to=%0b, want 0 0", cmd_valid, cmd_timeout);
        end
        open_turn(1'b0);
        cyc(13);
        key_r[0] = 1'b0;
        cyc(6);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL expiry_race_early: got valid=%0b, want 0", cmd_valid);
        end
        cyc(1);
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== HIT || cmd_timeout !== 1'b0) begin
            errors++;
            $display("FAIL expiry_race: got valid=%0b cmd=%0d to=%0b, want 1 1 0", cmd_valid, cmd, cmd_timeout);
        end
        ack_one();
        key_r[0] = 1'b1;
        turn_valid = 1'b0;
        cyc(DB + 4);
        $display("timeout: forced STAND, then press on expiry cycle gave HIT");
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_both_keys();
        test_other_player();
        test_turn_drop();
        test_random(2000);
`ifdef PLAYER_INPUT_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
